// File: rtl/pixel_stream_reader.sv
// Read master for the 24-bit RGB pixel RAM: fetches a run of words
// through a 1-cycle RAM port and streams R/G/B over valid/ready.
module pixel_stream_reader #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_q,
  output logic              px_valid,
  input  logic              px_ready,
  output logic [7:0]        px_r,
  output logic [7:0]        px_g,
  output logic [7:0]        px_b,
  output logic              px_last,
  output logic              busy,
  output logic              done
);

  localparam int CW = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [CW-1:0]     r_len;
  logic [CW-1:0]     r_issued;
  logic [CW-1:0]     r_accepted;
  logic              r_inflight;
  logic [1:0]        r_count;
  logic              r_head;
  logic [DATA_W-1:0] r_buf [2];

  logic              w_pop;
  logic              w_last;
  logic              w_wr_idx;
  logic [2:0]        w_occ;
  logic [DATA_W-1:0] w_head;

  assign w_head   = r_buf[r_head];
  assign px_valid = (r_count != 2'd0);
  assign w_pop    = px_valid & px_ready;
  assign w_last   = (r_accepted == r_len - CW'(1));
  // Occupancy after this cycle's return and pop; a new read needs a free slot.
  assign w_occ    = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
  // A return only lands when count <= 1, so the tail is head + count.
  assign w_wr_idx = r_head ^ r_count[0];

  assign mem_rd_en = (r_state == S_RUN) &&
                     (r_issued < r_len) &&
                     (w_occ < 3'd2);
  assign mem_addr  = r_base + r_issued[ADDR_W-1:0];

  assign px_r    = w_head[23:16];
  assign px_g    = w_head[15:8];
  assign px_b    = w_head[7:0];
  assign px_last = px_valid & w_last;
  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_len      <= '0;
      r_issued   <= '0;
      r_accepted <= '0;
      r_inflight <= 1'b0;
      r_count    <= 2'd0;
      r_head     <= 1'b0;
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
    end else begin
      r_inflight <= mem_rd_en;
      r_count    <= w_occ[1:0];
      if (mem_rd_en) r_issued <= r_issued + CW'(1);
      if (r_inflight) r_buf[w_wr_idx] <= mem_q;
      if (w_pop) begin
        r_head     <= ~r_head;
        r_accepted <= r_accepted + CW'(1);
      end
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base     <= base_addr;
            r_len      <= {1'b0, length};
            r_issued   <= '0;
            r_accepted <= '0;
            r_inflight <= 1'b0;
            r_count    <= 2'd0;
            r_head     <= 1'b0;
            r_state    <= (length == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (w_pop && w_last) r_state <= S_DONE;
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_stream_reader.sv
// Bench for pixel_stream_reader: directed and random transfers
// checked against a pixel-sequence model of the RAM run.
module tb_pixel_stream_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [17:0] base_addr = '0;
  logic [17:0] length = '0;
  logic        mem_rd_en;
  logic [17:0] mem_addr;
  logic [23:0] mem_q = '0;
  logic        px_valid;
  logic        px_ready = 1'b0;
  logic [7:0]  px_r, px_g, px_b;
  logic        px_last, busy, done;

  int checks = 0;
  int errors = 0;

  logic [23:0] ram [bit [17:0]];

  always #5 clk = ~clk;

  pixel_stream_reader #(.ADDR_W(18), .DATA_W(24)) dut (
    .clk(clk), .rst(rst), .start(start),
    .base_addr(base_addr), .length(length),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_q(mem_q),
    .px_valid(px_valid), .px_ready(px_ready),
    .px_r(px_r), .px_g(px_g), .px_b(px_b),
    .px_last(px_last), .busy(busy), .done(done)
  );

  function automatic logic [23:0] rdw(input logic [17:0] a);
    logic [31:0] h;
    if (ram.exists(a)) return ram[a];
    h = (32'(a) * 32'h9E3779B1) >> 7;
    return h[23:0];
  endfunction

  // Registered RAM read port
  always @(posedge clk) if (mem_rd_en) mem_q <= rdw(mem_addr);

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rd"}, mem_rd_en, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_valid"}, px_valid, 0);
    chk({tag, "_rgb"}, {px_r, px_g, px_b}, 0);
    chk({tag, "_last"}, px_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // mode 0: ready=1, 1: ready pattern 1,0,0, 2: random ready
  task automatic run_xfer(input logic [17:0] b, input logic [17:0] n,
                          input int mode, input bit tim, input bit poke);
    int nrd, npop, first_rd, first_v, done_cyc, lim;
    bit stalled;
    logic [23:0] prev, exp;
    logic [17:0] a;
    nrd = 0; npop = 0; first_rd = -1; first_v = -1; done_cyc = -1;
    stalled = 0; prev = '0;
    lim = 4 * int'(n) + 20;
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; length = n; px_ready = 1'b0;
    @(negedge clk);
    chk("c0_busy", busy, 0);
    for (int cyc = 1; cyc < lim && done_cyc < 0; cyc++) begin
      @(posedge clk); #1;
      start = poke && (cyc == 2);
      base_addr = b + 18'd7;
      length = n + 18'd3;
      case (mode)
        0: px_ready = 1'b1;
        1: px_ready = ((cyc - 1) % 3 == 0);
        default: px_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      chk("busy", busy, 1);
      if (mem_rd_en) begin
        a = b + 18'(nrd);
        chk("mem_addr", mem_addr, a);
        if (first_rd < 0) first_rd = cyc;
        nrd++;
      end
      chk("rd_bound", nrd <= int'(n), 1);
      if (stalled) begin
        chk("valid_hold", px_valid, 1);
        chk("stall_hold", {px_r, px_g, px_b}, prev);
      end
      stalled = 0;
      if (px_valid) begin
        a = b + 18'(npop);
        exp = rdw(a);
        chk("pixel", {px_r, px_g, px_b}, exp);
        chk("px_last", px_last, npop == int'(n) - 1);
        if (first_v < 0) first_v = cyc;
        prev = {px_r, px_g, px_b};
        if (px_ready) npop++;
        else stalled = 1;
      end else begin
        chk("last_no_valid", px_last, 0);
      end
      chk("occupancy", (nrd - npop) <= 2, 1);
      if (done) begin
        done_cyc = cyc;
        chk("done_count", npop, n);
      end
    end
    chk("done_seen", done_cyc >= 0, 1);
    chk("reads", nrd, n);
    if (tim) begin
      chk("t_first_rd", first_rd, (n == 0) ? -1 : 1);
      chk("t_first_valid", first_v, (n == 0) ? -1 : 3);
      chk("t_done", done_cyc, (n == 0) ? 1 : int'(n) + 3);
    end
    @(posedge clk); #1;
    start = 1'b0; px_ready = 1'b0;
    @(negedge clk);
    chk("post_busy", busy, 0);
    chk("post_done", done, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("after_reset");

    ram[18'h10] = 24'hFF0000;
    ram[18'h11] = 24'h00FF00;
    ram[18'h12] = 24'h0000FF;
    ram[18'h13] = 24'h123456;
    run_xfer(18'h00010, 18'd4, 0, 1, 0);
    run_xfer(18'h00010, 18'd4, 1, 0, 0);
    run_xfer(18'h00010, 18'd0, 0, 1, 0);
    run_xfer(18'h3FFFE, 18'd4, 0, 1, 0);
    run_xfer(18'h00040, 18'd6, 0, 1, 1);
    run_xfer(18'h00080, 18'd7, 1, 0, 1);
    run_xfer(18'h00090, 18'd1, 0, 1, 0);

    for (int k = 0; k < 6; k++)
      run_xfer(18'($urandom), 18'($urandom_range(1, 12)), 2, 0, 0);

    // Reset in cycle 4 of a length-8 transfer
    @(posedge clk); #1;
    start = 1'b1; base_addr = 18'h100; length = 18'd8;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      start = 1'b0; px_ready = 1'b1;
    end
    rst = 1'b1;
    #1;
    chk_idle_outputs("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst_no_done", done, 0);
      chk("rst_idle", busy, 0);
    end
    run_xfer(18'h00200, 18'd2, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_stream_reader.md
# pixel_stream_reader

Read-side master for the 24-bit RGB pixel RAM that the pipeline's memory stage writes through byte enables. On a start command it fetches a contiguous run of pixel words through the RAM's second read port (1-cycle registered read latency). It splits each word into R/G/B bytes and streams them out over a valid/ready handshake, for example toward a display or serial output block. A 2-entry prefetch buffer absorbs the RAM latency so the block sustains one pixel per cycle under no backpressure.

## Interface
- ADDR_W, 18, pixel RAM address width (matches the pipeline's ALU result width)
- DATA_W, 24, RAM word width; fixed at 24 (R = [23:16], G = [15:8], B = [7:0])

- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, asynchronous and active-high; clears all state
- start  in  1  one-cycle command, sampled only in IDLE
- base_addr  in  ADDR_W  first pixel address, sampled with start
- length  in  ADDR_W  number of pixels to read, sampled with start
- mem_rd_en  out  1  RAM read strobe
- mem_addr  out  ADDR_W  RAM read address, valid when mem_rd_en=1
- mem_q  in  DATA_W  RAM read data, valid the cycle after mem_rd_en
- px_valid  out  1  pixel available at buffer head
- px_ready  in  1  consumer accepts pixel
- px_r, px_g, px_b  out  8 each  pixel channels from the buffer head
- px_last  out  1  head pixel is index length-1
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse after the final pixel handshake

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1: latch base_addr and length, clear issue/accept counters, go to RUN.
  - If length=0: go to DONE directly; no RAM reads.
- RUN, read issue:
  - mem_rd_en=1 when issued<length and (count + inflight − pop) < 2.
    - count = buffer occupancy; inflight = read issued last cycle; pop = px_valid & px_ready this cycle.
  - mem_addr = base + issued, modulo 2^ADDR_W (wraps silently).
  - The issue counter increments on each read.
- Data return: mem_q is written into the buffer on the cycle after mem_rd_en. The buffer never overflows by construction.
- Output:
  - px_valid = (count ≠ 0). px_r/g/b come from the head word.
  - The head is popped on px_valid & px_ready. The accept counter increments per pop.
  - px_last = px_valid & (accepted == length−1).
  - px_r/g/b hold their value while px_valid=1 and px_ready=0.
- RUN→DONE on the pop of the final pixel. DONE asserts done=1 for one cycle, then returns to IDLE.
- busy = 1 in RUN and DONE; 0 in IDLE.
- start outside IDLE is ignored, including new base_addr/length.
- Counters are ADDR_W+1 bits wide so length = 2^ADDR_W−1 does not alias.

## Timing
- Reset values: state IDLE, buffer empty, counters 0, mem_rd_en=0, mem_addr=0, px_valid=0, px_r/g/b=0, px_last=0, busy=0, done=0.
- Cycle reference: start high in cycle 0.
  - Cycle 1: busy=1, mem_rd_en=1 at base.
  - Cycle 2: second read issued; first data returns on mem_q.
  - Cycle 3: px_valid=1.
- With px_ready held high: one pixel per cycle from cycle 3. The last pixel of N is in cycle N+2; done=1 in cycle N+3; IDLE in cycle N+4.
- A new start is accepted in the first IDLE cycle after done.
- length=0: done=1 in cycle 1; mem_rd_en never asserts.
- Backpressure: at most 2 reads are outstanding or buffered. Reads resume in the same cycle as the pop that frees a slot.
- rst mid-transfer: immediate return to reset values.
  - The in-flight RAM word (mem_q) is discarded.
  - No done pulse.

## Test plan
- base=0x00010, length=4, px_ready=1, RAM[0x10..0x13]=0xFF0000, 0x00FF00, 0x0000FF, 0x123456:
  - mem_rd_en in cycles 1–4 at addr 0x10..0x13.
  - px_valid in cycles 3–6 with (R,G,B) = (FF,00,00), (00,FF,00), (00,00,FF), (12,34,56).
  - px_last in cycle 6; done in cycle 7.
- Same transfer, px_ready toggling 1,0,0,1,…:
  - Pixels are delivered in order with no loss or duplication.
  - px_r/g/b are stable while stalled.
  - At no cycle do buffered plus inflight reads exceed 2.
- length=0 → done=1 in cycle 1, no mem_rd_en, px_valid stays 0.
- base=0x3FFFE, length=4 → mem_addr sequence 0x3FFFE, 0x3FFFF, 0x00000, 0x00001.
- start pulsed with different base/length while busy → ignored; original transfer completes unchanged.
- rst asserted in cycle 4 of a length-8 transfer:
  - All outputs at reset values in the same cycle.
  - No done pulse.
  - A new start (length=2) after deassertion completes normally.
